hazard_scoreboard: RTL and testbench
====================================

Name: hazard_scoreboard

Overview:
- Producer side of the operand-forwarding interface: tracks, per pipeline stage E/M/W, the destination register, write-enable and remaining T_new of every instruction issued from D.
- The forwarding mux-select logic consumes these signals.
- Generates the D-stage stall from T_use/T_new comparison and from a multiply/divide busy counter; inserts the E-stage bubble on stall.
- Sits beside the D/E, E/M and M/W pipeline registers.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu after entering E.
- DIV_CYCLES, 10, busy cycles for div/divu after entering E.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- rs_d  in  5  D-stage rs index
- rt_d  in  5  D-stage rt index
- use_rs_d  in  1  D instr reads rs
- use_rt_d  in  1  D instr reads rt
- tuse_rs_d  in  3  cycles from D until rs needed (0=D, 1=E, 2=M)
- tuse_rt_d  in  3  same for rt
- dst_d  in  5  D instr destination register (rt/rd/31)
- regw_d  in  1  D instr writes GPR
- tnew_d  in  3  cycles from E entry until result valid (ALU=1, load=2, jal=0)
- md_start_d  in  1  D instr is mult/multu/div/divu
- md_is_div_d  in  1  qualifies md_start_d as divide
- md_use_d  in  1  D instr is any HI/LO instr (mult/div/mfhi/mflo/mthi/mtlo)
- stall  out  1  freeze PC and F/D register, bubble into E
- rt_rdE, rt_rdM, rt_rdW  out  5 each  destination per stage
- regwE, regwM, regwW  out  1 each  write-enable per stage
- T_new_E, T_new_M, T_new_W  out  3 each  remaining cycles per stage
- md_busy  out  1  multiply/divide unit busy

Behaviour:
- Reset (synchronous, active-high): all stage fields 0, regw 0, T_new 0, busy counter 0. stall=0 and md_busy=0 the cycle after reset.
- Shift every clock. E-to-M: T_new_M <= sat0(T_new_E-1). M-to-W: T_new_W <= sat0(T_new_M-1).
- D-to-E when stall=0: rt_rdE <= dst_d; regwE <= regw_d & (dst_d!=0); T_new_E <= tnew_d.
- When stall=1: E loads a bubble (dst 0, regw 0, T_new 0). M and W still advance.
- Register $0 never creates a hazard or a forward source: regw forced 0 when dst=0.
- stall_rs = use_rs_d & rs_d!=0 & ((regwE & rs_d==rt_rdE & T_new_E>tuse_rs_d) | (regwM & rs_d==rt_rdM & T_new_M>tuse_rs_d)). stall_rt is symmetric.
  - W is never checked: T_new_W is always 0 by construction.
- E match takes precedence conceptually, but stall is the OR, so precedence does not matter for stall.
- stall_md = md_use_d & (md_busy | E holds an md start).
- stall = stall_rs | stall_rt | stall_md. Purely combinational from current state and D inputs.
- Busy counter (5-bit):
  - On the edge where a D instr with md_start_d moves to E (stall=0), cnt <= DIV_CYCLES if md_is_div_d, else MULT_CYCLES.
  - Otherwise, if cnt!=0, cnt <= cnt-1.
  - md_busy = (cnt!=0).
- A start instruction is only accepted when not busy, because md_use_d covers it. Load and decrement therefore never coincide.
- "E holds an md start" is a 1-bit flag tracked alongside E. It is cleared by a bubble.
- Reset mid-divide: counter cleared immediately at the edge; no residual stall.
- Stall is always released: T_new strictly decreases and the counter strictly decreases. Bound: ≤2 cycles for GPR hazards, ≤DIV_CYCLES+1 for MD hazards.

Decomposition:
- Shared package holds:
  - T_new/T_use encodings: TNEW_ALU=1, TNEW_LOAD=2, TNEW_LINK=0, TUSE_D=0, TUSE_E=1, TUSE_M=2.
  - 3-bit T width and 5-bit register-index width constants.
  - MULT_CYCLES/DIV_CYCLES defaults.
- One sub-module is natural: md_busy_counter (load/decrement/busy). Stage tracking stays inline.

Test Plan:
- lw $8 (tnew 2) in E, next D is add using rs=$8 (tuse 1) -> stall=1 for exactly 1 cycle; then rt_rdM=8, T_new_M=1, stall=0; the following cycle T_new_W=0.
- add $9 (tnew 1) in E, D is beq using rt=$9 (tuse 0) -> stall 1 cycle; next cycle T_new_M=0, regwM=1, rt_rdM=9, stall=0.
- lw $0 in E, D reads rs=$0 -> regwE=0, stall=0.
- div issued (DIV_CYCLES=10), then mflo in D -> stall high while cnt 10..1 plus the E cycle; md_busy falls after 10 cycles; mflo advances on the first cycle cnt=0.
- Stall cycle -> E shows rt_rdE=0, regwE=0, T_new_E=0 while M/W continue shifting (lw's M entry observed as T_new_M=1).
- Reset asserted at cnt=6 of a divide and with lw in E -> next cycle all outputs 0, stall=0, md_busy=0.

Source files
------------

// File: rtl/hazard_scoreboard_pkg.sv
// Shared encodings and widths for the hazard scoreboard: T_new/T_use codes,
// field widths and the default multiply/divide latencies.
package hazard_scoreboard_pkg;

    localparam int T_W   = 3;
    localparam int REG_W = 5;
    localparam int CNT_W = 5;

    localparam logic [T_W-1:0] TNEW_LINK = 3'd0;
    localparam logic [T_W-1:0] TNEW_ALU  = 3'd1;
    localparam logic [T_W-1:0] TNEW_LOAD = 3'd2;

    localparam logic [T_W-1:0] TUSE_D = 3'd0;
    localparam logic [T_W-1:0] TUSE_E = 3'd1;
    localparam logic [T_W-1:0] TUSE_M = 3'd2;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

    // Decrement that sticks at zero once the result is already available.
    function automatic logic [T_W-1:0] sat0_dec(input logic [T_W-1:0] t);
        return (t == '0) ? '0 : t - T_W'(1);
    endfunction

endpackage

// File: rtl/hazard_scoreboard_md_busy_counter.sv
// Multiply/divide occupancy counter: loaded when an md start enters E,
// then counts down to zero; busy while non-zero.
module hazard_scoreboard_md_busy_counter
    import hazard_scoreboard_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic i_load,
    input  logic i_is_div,
    output logic o_busy
);

    logic [CNT_W-1:0] r_cnt;

    // A new start is only accepted while idle, so load and decrement never overlap.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    assign o_busy = (r_cnt != '0);

endmodule

// File: rtl/hazard_scoreboard.sv
// Producer side of operand forwarding: tracks destination, write-enable and
// remaining T_new through E/M/W and raises the D-stage stall.
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [REG_W-1:0] rs_d,
    input  logic [REG_W-1:0] rt_d,
    input  logic             use_rs_d,
    input  logic             use_rt_d,
    input  logic [T_W-1:0]   tuse_rs_d,
    input  logic [T_W-1:0]   tuse_rt_d,
    input  logic [REG_W-1:0] dst_d,
    input  logic             regw_d,
    input  logic [T_W-1:0]   tnew_d,
    input  logic             md_start_d,
    input  logic             md_is_div_d,
    input  logic             md_use_d,
    output logic             stall,
    output logic [REG_W-1:0] rt_rdE,
    output logic [REG_W-1:0] rt_rdM,
    output logic [REG_W-1:0] rt_rdW,
    output logic             regwE,
    output logic             regwM,
    output logic             regwW,
    output logic [T_W-1:0]   T_new_E,
    output logic [T_W-1:0]   T_new_M,
    output logic [T_W-1:0]   T_new_W,
    output logic             md_busy
);

    logic [REG_W-1:0] r_dst_e, r_dst_m, r_dst_w;
    logic             r_regw_e, r_regw_m, r_regw_w;
    logic [T_W-1:0]   r_tnew_e, r_tnew_m, r_tnew_w;
    logic             r_md_e;

    logic w_stall_rs, w_stall_rt, w_stall_md, w_stall;
    logic w_md_busy, w_md_load;

    // W is never compared: its T_new has always drained to zero.
    assign w_stall_rs = use_rs_d && (rs_d != '0) &&
                        ((r_regw_e && (rs_d == r_dst_e) && (r_tnew_e > tuse_rs_d)) ||
                         (r_regw_m && (rs_d == r_dst_m) && (r_tnew_m > tuse_rs_d)));
    assign w_stall_rt = use_rt_d && (rt_d != '0) &&
                        ((r_regw_e && (rt_d == r_dst_e) && (r_tnew_e > tuse_rt_d)) ||
                         (r_regw_m && (rt_d == r_dst_m) && (r_tnew_m > tuse_rt_d)));
    assign w_stall_md = md_use_d && (w_md_busy || r_md_e);
    assign w_stall    = w_stall_rs || w_stall_rt || w_stall_md;
    assign w_md_load  = md_start_d && !w_stall;

    hazard_scoreboard_md_busy_counter #(
        .MULT_CYCLES (MULT_CYCLES),
        .DIV_CYCLES  (DIV_CYCLES)
    ) u_md_busy (
        .clk      (clk),
        .reset    (reset),
        .i_load   (w_md_load),
        .i_is_div (md_is_div_d),
        .o_busy   (w_md_busy)
    );

    // D->E (bubble on stall), E->M, M->W
    always_ff @(posedge clk) begin
        if (reset) begin
            r_dst_e  <= '0;
            r_regw_e <= 1'b0;
            r_tnew_e <= '0;
            r_md_e   <= 1'b0;
            r_dst_m  <= '0;
            r_regw_m <= 1'b0;
            r_tnew_m <= '0;
            r_dst_w  <= '0;
            r_regw_w <= 1'b0;
            r_tnew_w <= '0;
        end else begin
            if (w_stall) begin
                r_dst_e  <= '0;
                r_regw_e <= 1'b0;
                r_tnew_e <= '0;
                r_md_e   <= 1'b0;
            end else begin
                r_dst_e  <= dst_d;
                r_regw_e <= regw_d && (dst_d != '0);
                r_tnew_e <= tnew_d;
                r_md_e   <= md_start_d;
            end
            r_dst_m  <= r_dst_e;
            r_regw_m <= r_regw_e;
            r_tnew_m <= sat0_dec(r_tnew_e);
            r_dst_w  <= r_dst_m;
            r_regw_w <= r_regw_m;
            r_tnew_w <= sat0_dec(r_tnew_m);
        end
    end

    assign stall   = w_stall;
    assign md_busy = w_md_busy;
    assign rt_rdE  = r_dst_e;
    assign rt_rdM  = r_dst_m;
    assign rt_rdW  = r_dst_w;
    assign regwE   = r_regw_e;
    assign regwM   = r_regw_m;
    assign regwW   = r_regw_w;
    assign T_new_E = r_tnew_e;
    assign T_new_M = r_tnew_m;
    assign T_new_W = r_tnew_w;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: expectations queued per step and
// compared against the DUT outputs between clock edges.
module tb_hazard_scoreboard;
    import hazard_scoreboard_pkg::*;

    logic             clk = 1'b0;
    logic             reset;
    logic [REG_W-1:0] rs_d, rt_d, dst_d;
    logic             use_rs_d, use_rt_d, regw_d;
    logic [T_W-1:0]   tuse_rs_d, tuse_rt_d, tnew_d;
    logic             md_start_d, md_is_div_d, md_use_d;
    logic             stall, md_busy;
    logic [REG_W-1:0] rt_rdE, rt_rdM, rt_rdW;
    logic             regwE, regwM, regwW;
    logic [T_W-1:0]   T_new_E, T_new_M, T_new_W;

    hazard_scoreboard #(
        .MULT_CYCLES (5),
        .DIV_CYCLES  (10)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .rs_d        (rs_d),
        .rt_d        (rt_d),
        .use_rs_d    (use_rs_d),
        .use_rt_d    (use_rt_d),
        .tuse_rs_d   (tuse_rs_d),
        .tuse_rt_d   (tuse_rt_d),
        .dst_d       (dst_d),
        .regw_d      (regw_d),
        .tnew_d      (tnew_d),
        .md_start_d  (md_start_d),
        .md_is_div_d (md_is_div_d),
        .md_use_d    (md_use_d),
        .stall       (stall),
        .rt_rdE      (rt_rdE),
        .rt_rdM      (rt_rdM),
        .rt_rdW      (rt_rdW),
        .regwE       (regwE),
        .regwM       (regwM),
        .regwW       (regwW),
        .T_new_E     (T_new_E),
        .T_new_M     (T_new_M),
        .T_new_W     (T_new_W),
        .md_busy     (md_busy)
    );

    always #5 clk = ~clk;

    localparam int F_STALL = 0, F_BUSY = 1, F_DE = 2, F_WE = 3, F_TE = 4,
                   F_DM = 5, F_WM = 6, F_TM = 7, F_DW = 8, F_WW = 9, F_TW = 10;

    typedef struct {
        string tag;
        int    fid;
        int    val;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;

    function automatic int obs(input int f);
        case (f)
            F_STALL: return int'(stall);
            F_BUSY:  return int'(md_busy);
            F_DE:    return int'(rt_rdE);
            F_WE:    return int'(regwE);
            F_TE:    return int'(T_new_E);
            F_DM:    return int'(rt_rdM);
            F_WM:    return int'(regwM);
            F_TM:    return int'(T_new_M);
            F_DW:    return int'(rt_rdW);
            F_WW:    return int'(regwW);
            F_TW:    return int'(T_new_W);
            default: return -1;
        endcase
    endfunction

    task automatic push_exp(input string tag, input int fid, input int val);
        exp_t e;
        e.tag = tag;
        e.fid = fid;
        e.val = val;
        q.push_back(e);
    endtask

    task automatic push_all_zero(input string tag);
        for (int f = F_STALL; f <= F_TW; f++) push_exp(tag, f, 0);
    endtask

    task automatic check();
        exp_t e;
        int   o;
        #1;
        while (q.size() > 0) begin
            e = q.pop_front();
            o = obs(e.fid);
            checks++;
            assert (o === e.val) else begin
                failures++;
                $error("FAIL %s field=%0d observed=%0d expected=%0d", e.tag, e.fid, o, e.val);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int rs, input int rt, input int urs, input int urt,
                         input int trs, input int trt, input int dst, input int rw,
                         input int tn, input int mds, input int mdd, input int mdu);
        rs_d        = REG_W'(rs);
        rt_d        = REG_W'(rt);
        use_rs_d    = 1'(urs);
        use_rt_d    = 1'(urt);
        tuse_rs_d   = T_W'(trs);
        tuse_rt_d   = T_W'(trt);
        dst_d       = REG_W'(dst);
        regw_d      = 1'(rw);
        tnew_d      = T_W'(tn);
        md_start_d  = 1'(mds);
        md_is_div_d = 1'(mdd);
        md_use_d    = 1'(mdu);
    endtask

    task automatic drive_nop();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Issue an md start, then hold an mflo in D and expect exactly n stall cycles.
    task automatic md_run(input int is_div, input int n);
        drive(0, 0, 0, 0, 0, 0, 0, 0, int'(TNEW_ALU), 1, is_div, 1);
        push_exp("md_start_accepted", F_STALL, 0);
        push_exp("md_idle_before", F_BUSY, 0);
        check();
        tick();
        drive(0, 0, 0, 0, 0, 0, 11, 1, int'(TNEW_ALU), 0, 0, 1);
        for (int k = 0; k <= n; k++) begin
            push_exp("md_stall", F_STALL, int'(k < n));
            push_exp("md_busy", F_BUSY, int'(k < n));
            if (k == 1) push_exp("md_bubble_dst", F_DE, 0);
            check();
            tick();
        end
        drive_nop();
        push_exp("mflo_in_E_dst", F_DE, 11);
        push_exp("mflo_in_E_regw", F_WE, 1);
        push_exp("mflo_in_E_tnew", F_TE, 1);
        push_exp("md_idle_after", F_BUSY, 0);
        check();
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        drive_nop();
        tick();
        tick();
        push_all_zero("reset_state");
        check();
        reset = 1'b0;

        // lw $8 then add using $8 in E: one stall, bubble in E, lw continues to M/W
        drive(0, 0, 0, 0, 0, 0, 8, 1, int'(TNEW_LOAD), 0, 0, 0);
        tick();
        drive(8, 9, 1, 1, int'(TUSE_E), int'(TUSE_E), 10, 1, int'(TNEW_ALU), 0, 0, 0);
        push_exp("lw_add_stall", F_STALL, 1);
        push_exp("lw_in_E_dst", F_DE, 8);
        push_exp("lw_in_E_regw", F_WE, 1);
        push_exp("lw_in_E_tnew", F_TE, 2);
        check();
        tick();
        push_exp("lw_add_release", F_STALL, 0);
        push_exp("bubble_dst", F_DE, 0);
        push_exp("bubble_regw", F_WE, 0);
        push_exp("bubble_tnew", F_TE, 0);
        push_exp("lw_in_M_dst", F_DM, 8);
        push_exp("lw_in_M_regw", F_WM, 1);
        push_exp("lw_in_M_tnew", F_TM, 1);
        check();
        tick();
        drive_nop();
        push_exp("add_in_E_dst", F_DE, 10);
        push_exp("add_in_E_tnew", F_TE, 1);
        push_exp("lw_in_W_dst", F_DW, 8);
        push_exp("lw_in_W_regw", F_WW, 1);
        push_exp("lw_in_W_tnew", F_TW, 0);
        push_exp("bubble_in_M_regw", F_WM, 0);
        push_exp("no_stall_after", F_STALL, 0);
        check();
        tick();

        // add $9 then beq using rt=$9 at D
        drive(0, 0, 0, 0, 0, 0, 9, 1, int'(TNEW_ALU), 0, 0, 0);
        tick();
        drive(0, 9, 1, 1, int'(TUSE_D), int'(TUSE_D), 0, 0, 0, 0, 0, 0);
        push_exp("add_beq_stall", F_STALL, 1);
        push_exp("add_in_E_dst9", F_DE, 9);
        push_exp("add_in_E_tnew1", F_TE, 1);
        check();
        tick();
        push_exp("add_beq_release", F_STALL, 0);
        push_exp("add_in_M_dst", F_DM, 9);
        push_exp("add_in_M_regw", F_WM, 1);
        push_exp("add_in_M_tnew", F_TM, 0);
        check();
        tick();

        // lw $0: regw gated, reader of $0 never stalls
        drive(0, 0, 0, 0, 0, 0, 0, 1, int'(TNEW_LOAD), 0, 0, 0);
        tick();
        drive(0, 0, 1, 0, int'(TUSE_D), 0, 0, 0, 0, 0, 0, 0);
        push_exp("r0_regw_gated", F_WE, 0);
        push_exp("r0_tnew", F_TE, 2);
        push_exp("r0_no_stall", F_STALL, 0);
        check();
        drive_nop();
        tick();

        // lw $13 then beq rs=$13: stall from E then from M
        drive(0, 0, 0, 0, 0, 0, 13, 1, int'(TNEW_LOAD), 0, 0, 0);
        tick();
        drive(13, 0, 1, 0, int'(TUSE_D), 0, 0, 0, 0, 0, 0, 0);
        push_exp("m_hazard_stall_E", F_STALL, 1);
        check();
        tick();
        push_exp("m_hazard_stall_M", F_STALL, 1);
        push_exp("m_hazard_lw_M_dst", F_DM, 13);
        push_exp("m_hazard_lw_M_tnew", F_TM, 1);
        check();
        tick();
        push_exp("m_hazard_release", F_STALL, 0);
        push_exp("m_hazard_lw_W_dst", F_DW, 13);
        push_exp("m_hazard_lw_W_regw", F_WW, 1);
        check();
        drive_nop();
        tick();

        md_run(1, 10);
        md_run(0, 5);

        // reset in the middle of a divide with lw in E
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1);
        tick();
        drive_nop();
        tick();
        tick();
        tick();
        drive(0, 0, 0, 0, 0, 0, 12, 1, int'(TNEW_LOAD), 0, 0, 0);
        tick();
        push_exp("mid_div_busy", F_BUSY, 1);
        push_exp("mid_div_lw_dst", F_DE, 12);
        push_exp("mid_div_lw_regw", F_WE, 1);
        push_exp("mid_div_lw_tnew", F_TE, 2);
        check();
        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 5, 1, int'(TNEW_ALU), 0, 0, 1);
        push_exp("mid_div_mflo_stall", F_STALL, 1);
        check();
        tick();
        reset = 1'b0;
        push_all_zero("reset_mid_div");
        check();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
